// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer
// and a synchronous flush. It sits between pipeline stages where the
// downstream stage may stall and the hazard unit may squash in-flight beats.
//
// Handshake: a beat moves across an interface at the active clock edge when
// valid and ready are both 1 at that edge. A producer holds valid and its
// payload steady until the transfer happens. in_ready is registered and
// never depends combinationally on out_ready or in_valid, so ready chains
// between stages are broken at every stage.
//
// Parameters
//   WIDTH        payload width in bits
//   RESET_VAL    out_data value while the stage holds nothing (e.g. a NOP)
//   CLK_NEGEDGE  1: state updates on the falling clk edge, 0: rising edge
//
// Ports
//   clk        stage clock (active edge chosen by CLK_NEGEDGE)
//   reset      asynchronous, active-low reset
//   flush      synchronous squash of every held beat
//   in_valid   upstream presents a beat on in_data
//   in_ready   stage accepts a beat at the next active edge (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts out_data at the next active edge
//   out_data   payload to the next stage (registered)
//   occupancy  number of held beats, 0..2; this is also the FSM state code
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter bit               CLK_NEGEDGE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // The state code doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             clk_e;
  logic             in_xfer;
  logic             out_xfer;

  // Falling-edge builds simply run the same flops from an inverted clock.
  assign clk_e = CLK_NEGEDGE ? ~clk : clk;

  assign out_valid = (state == BUSY) || (state == FULL);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occupancy = state;

  assign in_xfer  = in_valid  & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  // Reset asserts immediately; its release is expected away from the active
  // edge, so the first active edge after release already runs normally.
  // in_ready_q is loaded with (next state != FULL) in every branch.
  always_ff @(posedge clk_e or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Flush wins over everything: an incoming beat is dropped, an outgoing
      // beat has already been taken by the consumer.
      state      <= EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          in_ready_q <= 1'b1;
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (out_xfer) begin
            state  <= EMPTY;
            main_q <= RESET_VAL;
          end else if (in_xfer) begin
            // Downstream stalled: park the new beat behind the current one.
            state      <= FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state      <= BUSY;
            main_q     <= skid_q;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          // Unused code (e.g. an upset flop): fall back to a clean empty stage.
          state      <= EMPTY;
          main_q     <= RESET_VAL;
          skid_q     <= RESET_VAL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Three stage instances run the same directed and random sequence in
// parallel, each in its own lane:
//   lane 0: WIDTH=32, RESET_VAL=32'h13, falling-edge clocking
//   lane 1: WIDTH=32, RESET_VAL=0,      rising-edge clocking
//   lane 2: WIDTH=8,  RESET_VAL=8'h13,  rising-edge clocking
// The reference for each lane is a depth-2 FIFO held as a queue: accepted
// beats are pushed, consumed beats are popped and compared, flush and reset
// empty it. The monitor samples on the edge opposite to the lane's active
// edge, while inputs change 1 time unit after the active edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input int lane_id, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got %h expected %h (t=%0t)", lane_id, name, act, exp, $time);
    end
  endtask

  for (genvar l = 0; l < 3; l++) begin : lane
    localparam int          W    = (l == 2) ? 8 : 32;
    localparam logic [31:0] RV   = (l == 1) ? 32'h0 : 32'h0000_0013;
    localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    localparam logic [31:0] RVM  = RV & MASK;
    localparam bit          NEG  = (l == 0);

    logic          rst_n     = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [1:0]    occupancy;
    logic [W-1:0]  od;
    logic [31:0]   out_data;
    logic          done = 1'b0;

    assign out_data = 32'(od);

    pipe_stage_skid #(
      .WIDTH      (W),
      .RESET_VAL  (RV[W-1:0]),
      .CLK_NEGEDGE(NEG)
    ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data[W-1:0]),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (od),
      .occupancy (occupancy)
    );

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    logic        stall = 1'b0;
    logic [31:0] held  = '0;

    always begin
      if (NEG) @(posedge clk); else @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall = 1'b0;
        chk(l, "rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk(l, "rst_out_data",  out_data, RVM);
        chk(l, "rst_in_ready",  {31'b0, in_ready}, 32'd1);
        chk(l, "rst_occupancy", {30'b0, occupancy}, 32'd0);
      end else begin
        int  n;
        bit  in_x;
        bit  out_x;
        n = exp_q.size();
        chk(l, "occupancy", {30'b0, occupancy}, 32'(n));
        chk(l, "in_ready",  {31'b0, in_ready}, {31'b0, (n < 2)});
        chk(l, "out_valid", {31'b0, out_valid}, {31'b0, (n > 0)});
        chk(l, "out_data",  out_data, (n > 0) ? exp_q[0] : RVM);
        if (stall) begin
          chk(l, "stall_valid", {31'b0, out_valid}, 32'd1);
          chk(l, "stall_data",  out_data, held);
        end
        in_x  = in_valid && (n < 2);
        out_x = out_ready && (n > 0);
        stall = (n > 0) && !out_ready && !flush;
        if (n > 0) held = exp_q[0];
        if (flush) begin
          exp_q.delete();
        end else begin
          if (out_x) void'(exp_q.pop_front());
          if (in_x)  exp_q.push_back(in_data & MASK);
        end
      end
    end

    // ---------------- driver ----------------
    task automatic act();
      if (NEG) @(negedge clk); else @(posedge clk);
      #1;
    endtask

    task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      act();
      in_valid = 1'b0;
    endtask

    initial begin
      // Power-up reset (the #1 gives a clean falling edge on reset).
      #1 rst_n = 1'b0;
      repeat (2) act();
      chk(l, "por_occupancy", {30'b0, occupancy}, 32'd0);
      chk(l, "por_out_data",  out_data, RVM);
      rst_n = 1'b1;
      act();

      // Stall: two beats fill main + skid, then drain in order.
      out_ready = 1'b0;
      send(32'h11);
      send(32'h22);
      chk(l, "stall_occ2",    {30'b0, occupancy}, 32'd2);
      chk(l, "stall_inready", {31'b0, in_ready}, 32'd0);
      chk(l, "stall_head",    out_data, 32'h11 & MASK);
      act();
      chk(l, "stall_hold",    out_data, 32'h11 & MASK);
      out_ready = 1'b1;
      act();
      chk(l, "drain1_data",   out_data, 32'h22 & MASK);
      chk(l, "drain1_inrdy",  {31'b0, in_ready}, 32'd1);
      act();
      chk(l, "drain2_valid",  {31'b0, out_valid}, 32'd0);
      chk(l, "drain2_data",   out_data, RVM);

      // Asynchronous reset while full.
      out_ready = 1'b0;
      send(32'h44);
      send(32'h55);
      chk(l, "prerst_occ",    {30'b0, occupancy}, 32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk(l, "arst_valid",    {31'b0, out_valid}, 32'd0);
      chk(l, "arst_data",     out_data, RVM);
      chk(l, "arst_inready",  {31'b0, in_ready}, 32'd1);
      chk(l, "arst_occ",      {30'b0, occupancy}, 32'd0);
      act();
      rst_n = 1'b1;
      send(32'hA5A5_0001);
      chk(l, "post_rst_valid", {31'b0, out_valid}, 32'd1);
      chk(l, "post_rst_data",  out_data, 32'hA5A5_0001 & MASK);
      out_ready = 1'b1;
      act();

      // Flush with a simultaneous incoming beat.
      out_ready = 1'b0;
      send(32'h66);
      in_valid = 1'b1;
      in_data  = 32'h33;
      flush    = 1'b1;
      act();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk(l, "flush_occ",     {30'b0, occupancy}, 32'd0);
      chk(l, "flush_valid",   {31'b0, out_valid}, 32'd0);
      chk(l, "flush_data",    out_data, RVM);
      chk(l, "flush_inready", {31'b0, in_ready}, 32'd1);
      act();
      chk(l, "flush_drop",    {31'b0, out_valid}, 32'd0);

      // Streaming at one beat per cycle with one cycle of latency.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 100; i++) begin
        in_data = 32'(i);
        act();
        chk(l, "stream_valid", {31'b0, out_valid}, 32'd1);
        chk(l, "stream_data",  out_data, 32'(i) & MASK);
      end
      in_valid = 1'b0;
      act();

      // Random valid/ready/flush traffic.
      for (int c = 0; c < 10000; c++) begin
        in_valid  = ($urandom_range(0, 99) < 60);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 99) < 55);
        flush     = ($urandom_range(0, 199) < 3);
        act();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) act();
      chk(l, "final_occ", {30'b0, occupancy}, 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done && lane[2].done);
      #2000000;
    join_any
    if (!(lane[0].done && lane[1].done && lane[2].done)) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes did not complete within the time limit");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
